// File: rtl/load_use_hazard_ctrl.sv
// load_use_hazard_ctrl: freezes IF/ID and bubbles EX while a load feeding the ID instr is outstanding, with saturating perf counters
module load_use_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_AW-1:0]    id_rs1,
  input  logic [REG_AW-1:0]    id_rs2,
  input  logic                 id_rs1_ren,
  input  logic                 id_rs2_ren,
  input  logic                 ex_valid,
  input  logic                 ex_rf_we,
  input  logic [REG_AW-1:0]    ex_rf_waddr,
  input  logic                 ex_is_load,
  input  logic                 ls_valid,
  input  logic [REG_AW-1:0]    ls_rf_waddr,
  input  logic                 ls_load_done,
  input  logic                 flush,
  output logic                 if_stall,
  output logic                 id_stall,
  output logic                 ex_bubble,
  output logic                 hz_busy,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] load_use_events
);
  typedef enum logic {S_RUN, S_WAIT} state_t;
  state_t state, state_nx;
  logic [REG_AW-1:0] pend_addr;
  logic [CNT_WIDTH-1:0] sc_q, ev_q;
  logic match, done, hit, stall;
  always_comb begin
    match = id_valid & ex_valid & ex_is_load & ex_rf_we & (ex_rf_waddr != '0) &
            ((id_rs1_ren & (id_rs1 == ex_rf_waddr)) | (id_rs2_ren & (id_rs2 == ex_rf_waddr)));
    done = ls_valid & ls_load_done & (ls_rf_waddr == pend_addr);
    hit = (state == S_RUN) & match & !flush;
    stall = !rst & !flush & ((state == S_RUN) ? match : !done);
    state_nx = (flush | ((state == S_RUN) ? !match : done)) ? S_RUN : S_WAIT;
  end
  assign if_stall = stall;
  assign id_stall = stall;
  assign ex_bubble = stall;
  assign hz_busy = !rst & (state == S_WAIT);
  assign stall_cycles = rst ? '0 : sc_q;
  assign load_use_events = rst ? '0 : ev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RUN;
      pend_addr <= '0;
      sc_q <= '0;
      ev_q <= '0;
    end else begin
      state <= state_nx;
      if (hit) begin
        pend_addr <= ex_rf_waddr;
        ev_q <= ev_q + CNT_WIDTH'(!(&ev_q));
      end
      if (stall) sc_q <= sc_q + CNT_WIDTH'(!(&sc_q));
    end
  end
endmodule
